hog_frame_dispatch: RTL and testbench
=====================================

// Module: hog_frame_dispatch
// PURPOSE
//  Multi-engine successor to the single fetch->HOG/SVM path. Sits between axi_frame_fetch
//  (cell stream out) and ENG_AMT parallel hog_svm engines. Buffers cells in a small FIFO and
//  routes each whole frame (CELL_NUM cells) to one idle engine, chosen round-robin.
//  Frames are never split across engines.
// PARAMETERS
//  ENG_AMT     2     number of hog_svm engines (>=1)
//  CELL_WIDTH  768   bits per cell (8x8 pix + border, as produced by frame fetch)
//  CELL_NUM    1200  cells per frame (FRAME_ROW_CNUM*FRAME_COL_CNUM)
//  FIFO_DEPTH  4     cell FIFO entries, power of two, >=2
//  ENG_ID_W    (ENG_AMT>1)?$clog2(ENG_AMT):1   engine index width
// PORTS
//  clk           in   1                     clock
//  rst           in   1                     synchronous reset, active-high
//  cell_data_i   in   CELL_WIDTH            cell from frame fetch
//  cell_valid_i  in   1                     cell valid
//  cell_ready_o  out  1                     FIFO can accept (= !full)
//  eng_data_o    out  CELL_WIDTH            shared data bus to all engines (FIFO head)
//  eng_valid_o   out  ENG_AMT               one-hot valid, only selected engine
//  eng_ready_i   in   ENG_AMT               per-engine request/ready
//  eng_busy_i    in   ENG_AMT               engine still processing previous frame
//  active_eng_o  out  ENG_ID_W              engine currently owning the stream
//  cell_idx_o    out  $clog2(CELL_NUM)      index of next cell to dispatch in frame
//  frame_done_o  out  1                     1-cycle pulse: last cell of frame accepted
//  stall_cnt_o   out  32                    see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=SELECT, rr pointer=ENG_AMT-1 (first pick engine 0).
//  Input: push when cell_valid_i & cell_ready_o; independent of FSM state (buffering continues
//   during SELECT). Full FIFO -> cell_ready_o=0 even if a pop occurs that cycle (no pass-through).
//  Latency: accepted cell visible on eng_data_o no earlier than next cycle (no empty bypass).
//  FSM SELECT: scan engines from rr+1 wrapping mod ENG_AMT; first with eng_busy_i=0 is latched
//   into active_eng_o, rr<=it, -> STREAM next cycle. None idle -> stay SELECT.
//  FSM STREAM: eng_valid_o[active]=!empty, others 0. Pop on valid&eng_ready_i[active];
//   cell_idx_o++ on pop. Pop at cell_idx_o==CELL_NUM-1: frame_done_o=1 that cycle's next edge,
//   cell_idx_o<=0, -> SELECT. eng_busy_i of active engine ignored while in STREAM.
//  eng_valid_o never drops once asserted without a pop (AXI-style hold); eng_data_o stable meanwhile.
//  ENG_AMT=1: SELECT waits for engine 0 idle, rr logic degenerates.
//  Simultaneous push+pop when not full: both occur, occupancy unchanged.
//  Reset mid-frame: frame abandoned, FIFO flushed, cell_idx_o=0; no frame_done_o.
// CONFIGURATION
//  HOG_DISPATCH_STALL_CNT_EN defined: stall_cnt_o counts cycles in SELECT with !empty FIFO
//   (frame waiting, all engines busy); saturates at 32'hFFFF_FFFF; cleared by rst only.
//  Not defined: no counter logic; stall_cnt_o tied to 0.
// STRUCTURE
//  Shared package hog_pkg: FSM state enum (SELECT, STREAM), CELL_WIDTH/CELL_NUM defaults,
//   round-robin find-first helper function.
//  One sub-module: hog_cell_fifo (sync FIFO, registered full/empty, parameter width/depth).
//  Dispatcher FSM, rr pointer, counters stay in this module.
// TESTING (bench params ENG_AMT=2, CELL_NUM=4, FIFO_DEPTH=4)
//  1 8 cells back-to-back, busy=00, ready=11 -> cells 0-3 on eng_valid_o=01, done pulse,
//    cells 4-7 on eng_valid_o=10, data in order, 2 done pulses.
//  2 busy=01 at first SELECT -> frame 0 goes to engine 1; active_eng_o=1.
//  3 busy=11 for 10 cycles with 4 cells queued -> no eng_valid_o, cell_ready_o=0 after 4
//    cells, stall_cnt_o=10 (macro on) / 0 (off); release -> engine 0 served.
//  4 eng_ready_i toggling 1010... mid-frame -> eng_data_o/eng_valid_o held while not ready, no loss.
//  5 rst at cell 2 of frame -> next frame after reset starts cell_idx_o=0 on engine 0, no done pulse.
//  6 ENG_AMT=1 build: 3 frames, busy pulsed between frames -> strictly sequential on engine 0.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared types and helpers for the HOG frame dispatcher.
// Holds the dispatcher state enum, the default cell geometry and the
// round-robin find-first helper that picks the next idle engine.
package hog_pkg;

  localparam int CELL_WIDTH_DEF = 768;
  localparam int CELL_NUM_DEF   = 1200;
  // Widest engine vector the round-robin helper can scan.
  localparam int MAX_ENG        = 32;

  typedef enum logic {
    ST_SELECT = 1'b0,
    ST_STREAM = 1'b1
  } disp_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // Scans engines starting one past 'last', wrapping modulo 'amt', and
  // returns the first engine whose busy bit is clear.
  function automatic rr_pick_t rr_find_first(input logic [MAX_ENG-1:0] busy,
                                             input int unsigned       last,
                                             input int unsigned       amt);
    rr_pick_t    r;
    int unsigned cand;
    r = '0;
    for (int unsigned i = 0; i < MAX_ENG; i++) begin
      if (i < amt && !r.found) begin
        cand = (last + 1 + i) % amt;
        if (!busy[cand[4:0]]) begin
          r.found = 1'b1;
          r.idx   = cand[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hog_cell_fifo.sv
// Synchronous cell FIFO with registered full/empty flags.
// Head entry is presented combinationally from storage; a write only becomes
// visible on rdata the cycle after it is accepted (no empty bypass).
module hog_cell_fifo #(
  parameter int WIDTH = 768,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage write; contents need no reset since empty gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and flags, all flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/hog_frame_dispatch.sv
// Routes whole frames of cells from frame fetch to one of ENG_AMT HOG/SVM
// engines, picking the next idle engine round-robin. Cells are buffered in a
// small FIFO that keeps filling while an engine is being chosen.
// Optional build macro HOG_DISPATCH_STALL_CNT_EN enables the stall counter
// (cycles spent waiting for an idle engine with cells queued); without it
// stall_cnt_o is tied to zero.
module hog_frame_dispatch
  import hog_pkg::*;
#(
  parameter int ENG_AMT    = 2,
  parameter int CELL_WIDTH = CELL_WIDTH_DEF,
  parameter int CELL_NUM   = CELL_NUM_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int ENG_ID_W  = (ENG_AMT > 1) ? $clog2(ENG_AMT) : 1,
  localparam int IDX_W     = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CELL_WIDTH-1:0] cell_data_i,
  input  logic                  cell_valid_i,
  output logic                  cell_ready_o,
  output logic [CELL_WIDTH-1:0] eng_data_o,
  output logic [ENG_AMT-1:0]    eng_valid_o,
  input  logic [ENG_AMT-1:0]    eng_ready_i,
  input  logic [ENG_AMT-1:0]    eng_busy_i,
  output logic [ENG_ID_W-1:0]   active_eng_o,
  output logic [IDX_W-1:0]      cell_idx_o,
  output logic                  frame_done_o,
  output logic [31:0]           stall_cnt_o
);

  disp_state_t           state;
  logic [ENG_ID_W-1:0]   rr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CELL_WIDTH-1:0] fifo_head;
  logic                  push;
  logic                  pop;
  logic [MAX_ENG-1:0]    busy_ext;
  rr_pick_t              pick;
  logic                  unused_pick;

  assign push         = cell_valid_i & ~fifo_full;
  assign cell_ready_o = ~fifo_full;
  assign pop          = (state == ST_STREAM) & ~fifo_empty & eng_ready_i[active_eng_o];
  assign eng_data_o   = fifo_empty ? '0 : fifo_head;

  assign busy_ext    = MAX_ENG'(eng_busy_i);
  assign pick        = rr_find_first(busy_ext, 32'(rr), 32'(ENG_AMT));
  assign unused_pick = ^pick.idx;

  hog_cell_fifo #(
    .WIDTH (CELL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (cell_data_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only the engine owning the stream sees valid, and only with a cell queued.
  always_comb begin
    eng_valid_o = '0;
    if (state == ST_STREAM && !fifo_empty) eng_valid_o[active_eng_o] = 1'b1;
  end

  // Dispatcher FSM: pick an idle engine, then stream exactly one frame to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SELECT;
      active_eng_o <= '0;
      rr           <= ENG_ID_W'(ENG_AMT - 1);
      cell_idx_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        ST_SELECT: begin
          if (pick.found) begin
            active_eng_o <= pick.idx[ENG_ID_W-1:0];
            rr           <= pick.idx[ENG_ID_W-1:0];
            state        <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            if (cell_idx_o == IDX_W'(CELL_NUM - 1)) begin
              cell_idx_o   <= '0;
              frame_done_o <= 1'b1;
              state        <= ST_SELECT;
            end else begin
              cell_idx_o <= cell_idx_o + IDX_W'(1);
            end
          end
        end
        default: state <= ST_SELECT;
      endcase
    end
  end

`ifdef HOG_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles a queued frame waits for an idle engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == ST_SELECT && !fifo_empty && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hog_frame_dispatch.sv
// Directed bench for hog_frame_dispatch: a two-engine instance and a
// single-engine instance, both with 4-cell frames and a 4-entry FIFO.
module tb_hog_frame_dispatch;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // two-engine instance
  logic [W-1:0]  cell_data;
  logic          cell_valid;
  logic          cell_ready;
  logic [W-1:0]  eng_data;
  logic [1:0]    eng_valid;
  logic [1:0]    eng_ready;
  logic [1:0]    eng_busy;
  logic [0:0]    active_eng;
  logic [1:0]    cell_idx;
  logic          frame_done;
  logic [31:0]   stall_cnt;

  // single-engine instance
  logic [W-1:0]  s_cell_data;
  logic          s_cell_valid;
  logic          s_cell_ready;
  logic [W-1:0]  s_eng_data;
  logic [0:0]    s_eng_valid;
  logic [0:0]    s_eng_ready;
  logic [0:0]    s_eng_busy;
  logic [0:0]    s_active;
  logic [1:0]    s_cell_idx;
  logic          s_frame_done;
  logic [31:0]   s_stall_cnt;

  int tests_run = 0;
  int failures  = 0;

  hog_frame_dispatch #(.ENG_AMT(2), .CELL_WIDTH(W), .CELL_NUM(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cell_data_i(cell_data), .cell_valid_i(cell_valid), .cell_ready_o(cell_ready),
    .eng_data_o(eng_data), .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
    .eng_busy_i(eng_busy), .active_eng_o(active_eng), .cell_idx_o(cell_idx),
    .frame_done_o(frame_done), .stall_cnt_o(stall_cnt)
  );

  hog_frame_dispatch #(.ENG_AMT(1), .CELL_WIDTH(W), .CELL_NUM(4), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst),
    .cell_data_i(s_cell_data), .cell_valid_i(s_cell_valid), .cell_ready_o(s_cell_ready),
    .eng_data_o(s_eng_data), .eng_valid_o(s_eng_valid), .eng_ready_i(s_eng_ready),
    .eng_busy_i(s_eng_busy), .active_eng_o(s_active), .cell_idx_o(s_cell_idx),
    .frame_done_o(s_frame_done), .stall_cnt_o(s_stall_cnt)
  );

  // observation logs
  int           pop_eng[$];
  logic [W-1:0] pop_data[$];
  int           done_cnt;
  int           hold_err;
  int           onehot_err;
  logic [1:0]   prev_valid;
  logic [W-1:0] prev_data;
  logic         stalled;
  logic [W-1:0] s_pop_data[$];
  int           s_done_cnt;

  always @(posedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && (eng_valid !== prev_valid || eng_data !== prev_data)) hold_err++;
      if (eng_valid == 2'b11) onehot_err++;
      if (frame_done) done_cnt++;
      if ((eng_valid & eng_ready) != 2'b00) begin
        pop_eng.push_back(eng_valid[1] ? 1 : 0);
        pop_data.push_back(eng_data);
      end
      stalled    = (eng_valid != 2'b00) && ((eng_valid & eng_ready) == 2'b00);
      prev_valid = eng_valid;
      prev_data  = eng_data;
      if (s_frame_done) s_done_cnt++;
      if (s_eng_valid[0] && s_eng_ready[0]) s_pop_data.push_back(s_eng_data);
    end
  end

  task automatic clear_logs();
    pop_eng.delete();
    pop_data.delete();
    s_pop_data.delete();
    done_cnt   = 0;
    hold_err   = 0;
    onehot_err = 0;
    s_done_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cell_valid = 1'b0;
    s_cell_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  // Offers n cells (base, base+1, ...) and returns once all were accepted.
  task automatic send(input int which, input int n, input int base);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      if (which == 0) begin
        cell_data = W'(base + i);
        cell_valid = 1'b1;
        while (!cell_ready && guard < 200) begin @(negedge clk); guard++; end
      end else begin
        s_cell_data = W'(base + i);
        s_cell_valid = 1'b1;
        while (!s_cell_ready && guard < 200) begin @(negedge clk); guard++; end
      end
      if (guard >= 200) begin
        tests_run++; failures++;
        $display("FAIL send_timeout: cell %0d not accepted, ready stayed 0, required 1", i);
      end
      @(negedge clk);
    end
    cell_valid = 1'b0;
    s_cell_valid = 1'b0;
  endtask

  task automatic wait_pops(input int which, input int n, input string name);
    int guard;
    guard = 0;
    while (((which == 0) ? pop_data.size() : s_pop_data.size()) < n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (((which == 0) ? pop_data.size() : s_pop_data.size()) < n) begin
      failures++;
      $display("FAIL %s_pop_count: got %0d cells, required %0d", name,
               (which == 0) ? pop_data.size() : s_pop_data.size(), n);
    end
  endtask

  task automatic check_pops(input string name, input int n, input int base, input int eng_first,
                            input int eng_second);
    int exp_eng;
    for (int i = 0; i < n && i < pop_data.size(); i++) begin
      exp_eng = (i < 4) ? eng_first : eng_second;
      tests_run++;
      if (pop_eng[i] !== exp_eng || pop_data[i] !== W'(base + i)) begin
        failures++;
        $display("FAIL %s_cell%0d: eng %0d data %h, required eng %0d data %h",
                 name, i, pop_eng[i], pop_data[i], exp_eng, W'(base + i));
      end
    end
  endtask

  task automatic test_reset();
    eng_busy = 2'b00; eng_ready = 2'b11;
    s_eng_busy = 1'b0; s_eng_ready = 1'b1;
    do_reset();
    tests_run++;
    if (cell_ready !== 1'b1 || eng_valid !== 2'b00 || active_eng !== 1'b0 ||
        cell_idx !== 2'd0 || frame_done !== 1'b0 || stall_cnt !== 32'd0 || eng_data !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy %b vld %b act %0d idx %0d done %b stall %0d data %h, required 1 00 0 0 0 0 0",
               cell_ready, eng_valid, active_eng, cell_idx, frame_done, stall_cnt, eng_data);
    end
    tests_run++;
    if (s_cell_ready !== 1'b1 || s_eng_valid !== 1'b0 || s_cell_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_single: rdy %b vld %b idx %0d, required 1 0 0", s_cell_ready, s_eng_valid, s_cell_idx);
    end
  endtask

  task automatic test_back_to_back();
    eng_busy = 2'b00; eng_ready = 2'b11;
    do_reset();
    send(0, 8, 'h100);
    wait_pops(0, 8, "b2b");
    repeat (2) @(negedge clk);
    check_pops("b2b", 8, 'h100, 0, 1);
    tests_run++;
    if (done_cnt !== 2 || onehot_err !== 0) begin
      failures++;
      $display("FAIL b2b_done: pulses %0d onehot_err %0d, required 2 0", done_cnt, onehot_err);
    end
  endtask

  task automatic test_busy_skip();
    eng_busy = 2'b01; eng_ready = 2'b11;
    do_reset();
    @(negedge clk);
    tests_run++;
    if (active_eng !== 1'b1) begin
      failures++;
      $display("FAIL busy_skip_active: got %0d, required 1", active_eng);
    end
    send(0, 4, 'h200);
    wait_pops(0, 4, "busy_skip");
    check_pops("busy_skip", 4, 'h200, 1, 1);
    eng_busy = 2'b00;
  endtask

  task automatic test_stall();
    int viol;
    logic [31:0] exp_stall;
    eng_busy = 2'b11; eng_ready = 2'b11;
    do_reset();
    viol = 0;
    cell_data = W'('h300); cell_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      cell_data = W'('h300 + i);
      if (eng_valid !== 2'b00) viol++;
    end
    tests_run++;
    if (cell_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_full_ready: got %b, required 0", cell_ready);
    end
    for (int k = 5; k <= 11; k++) begin
      @(negedge clk);
      if (eng_valid !== 2'b00) viol++;
    end
`ifdef HOG_DISPATCH_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    tests_run++;
    if (stall_cnt !== exp_stall) begin
      failures++;
      $display("FAIL stall_count: got %0d, required %0d", stall_cnt, exp_stall);
    end
    tests_run++;
    if (viol !== 0 || cell_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_valid: valid seen %0d times rdy %b, required 0 times rdy 0", viol, cell_ready);
    end
    cell_valid = 1'b0;
    eng_busy = 2'b00;
    @(negedge clk);
    tests_run++;
    if (active_eng !== 1'b0 || eng_valid !== 2'b01) begin
      failures++;
      $display("FAIL stall_release: act %0d vld %b, required 0 01", active_eng, eng_valid);
    end
    wait_pops(0, 4, "stall");
    check_pops("stall", 4, 'h300, 0, 0);
  endtask

  task automatic test_ready_toggle();
    eng_busy = 2'b00; eng_ready = 2'b11;
    do_reset();
    fork
      send(0, 4, 'h380);
      begin
        for (int k = 0; k < 24; k++) begin
          eng_ready = {1'b1, ~k[0]};
          @(negedge clk);
        end
      end
    join
    eng_ready = 2'b11;
    wait_pops(0, 4, "toggle");
    repeat (3) @(negedge clk);
    check_pops("toggle", 4, 'h380, 0, 0);
    tests_run++;
    if (pop_data.size() !== 4 || hold_err !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL toggle_hold: cells %0d hold_err %0d done %0d, required 4 0 1",
               pop_data.size(), hold_err, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    eng_busy = 2'b00; eng_ready = 2'b00;
    do_reset();
    send(0, 4, 'h400);
    eng_ready = 2'b01;
    guard = 0;
    while (cell_idx !== 2'd2 && guard < 50) begin @(negedge clk); guard++; end
    tests_run++;
    if (cell_idx !== 2'd2) begin
      failures++;
      $display("FAIL mid_reach_idx2: got %0d, required 2", cell_idx);
    end
    rst = 1'b1;
    eng_ready = 2'b11;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    tests_run++;
    if (cell_idx !== 2'd0 || eng_valid !== 2'b00 || cell_ready !== 1'b1 || active_eng !== 1'b0) begin
      failures++;
      $display("FAIL mid_after_reset: idx %0d vld %b rdy %b act %0d, required 0 00 1 0",
               cell_idx, eng_valid, cell_ready, active_eng);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (done_cnt !== 0 || pop_data.size() !== 0) begin
      failures++;
      $display("FAIL mid_flushed: done %0d cells %0d, required 0 0", done_cnt, pop_data.size());
    end
    send(0, 4, 'h410);
    wait_pops(0, 4, "mid");
    repeat (2) @(negedge clk);
    check_pops("mid", 4, 'h410, 0, 0);
    tests_run++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL mid_done: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_single_engine();
    int viol;
    s_eng_busy = 1'b1; s_eng_ready = 1'b1;
    do_reset();
    viol = 0;
    for (int f = 0; f < 3; f++) begin
      send(1, 4, 'h500 + 16 * f);
      repeat (2) begin
        if (s_eng_valid !== 1'b0) viol++;
        @(negedge clk);
      end
      if (s_eng_valid !== 1'b0) viol++;
      s_eng_busy = 1'b0;
      wait_pops(1, 4 * (f + 1), "single");
      s_eng_busy = 1'b1;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (viol !== 0 || s_done_cnt !== 3 || s_active !== 1'b0) begin
      failures++;
      $display("FAIL single_seq: valid_while_busy %0d done %0d act %0d, required 0 3 0",
               viol, s_done_cnt, s_active);
    end
    for (int i = 0; i < 12 && i < s_pop_data.size(); i++) begin
      tests_run++;
      if (s_pop_data[i] !== W'('h500 + 16 * (i / 4) + (i % 4))) begin
        failures++;
        $display("FAIL single_cell%0d: got %h, required %h", i, s_pop_data[i],
                 W'('h500 + 16 * (i / 4) + (i % 4)));
      end
    end
    s_eng_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cell_data = '0; cell_valid = 1'b0;
    eng_ready = 2'b11; eng_busy = 2'b00;
    s_cell_data = '0; s_cell_valid = 1'b0;
    s_eng_ready = 1'b1; s_eng_busy = 1'b0;
    clear_logs();
    stalled = 1'b0;
    prev_valid = '0;
    prev_data = '0;
    test_reset();
    test_back_to_back();
    test_busy_skip();
    test_stall();
    test_ready_toggle();
    test_reset_mid();
    test_single_engine();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
